// File: rtl/clk_reset_pkg.sv
// Shared types and helpers for the clock/reset sequencer: FSM encodings and
// sizing of the single shared timer.
package clk_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_e;

    // Timer must reach (largest terminal count - 1); never narrower than 1 bit.
    function automatic int timer_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-deep single-bit synchroniser with synchronous clear.
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) sr <= '0;
        else     sr <= {sr[N-2:0], d};
    end

    assign q = sr[N-1];

endmodule

// File: rtl/clk_reset_seq.sv
// PLL lock supervisor: resets the PLL, qualifies lock, releases NCH reset
// channels in staggered order, and re-holds reset on lock loss.
module clk_reset_seq
    import clk_reset_pkg::*;
#(
    parameter int NSYNC          = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES  = 256,
    parameter int NCH            = 3,
    parameter int STAGGER        = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_raw,
    output logic             pll_resetb,
    output logic [NCH-1:0]   rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] relock_count,
    output logic             timeout_err
);

    localparam int TW = timer_w(TIMEOUT_CYCLES, STABLE_CYCLES, PLL_RST_CYCLES,
                                STAGGER * (NCH - 1) + 1);

    logic          lock_s;
    seq_state_e    state;
    logic [TW-1:0] timer;

    sync_bit #(.N(NSYNC)) u_lock_sync (
        .clk (clk),
        .clr (rst),
        .d   (lock_raw),
        .q   (lock_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PLL_RST;
            timer        <= '0;
            pll_resetb   <= 1'b0;
            rst_out      <= '1;
            ready        <= 1'b0;
            relock_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timer <= timer + 1'b1;
            unique case (state)
                PLL_RST: begin
                    if (int'(timer) == PLL_RST_CYCLES - 1) begin
                        state      <= WAIT_LOCK;
                        timer      <= '0;
                        pll_resetb <= 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        timer <= '0;
                    end else if (int'(timer) == TIMEOUT_CYCLES - 1) begin
                        state       <= PLL_RST;
                        timer       <= '0;
                        pll_resetb  <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (int'(timer) == STABLE_CYCLES - 1) begin
                        // Channel 0 drops on the same edge RELEASE is entered.
                        state      <= RELEASE;
                        timer      <= '0;
                        rst_out[0] <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        rst_out <= '1;
                        ready   <= 1'b0;
                    end else if (int'(timer) == STAGGER * (NCH - 1)) begin
                        state <= RUN;
                        timer <= '0;
                        ready <= 1'b1;
                    end else begin
                        for (int i = 1; i < NCH; i++)
                            if (int'(timer) + 1 == STAGGER * i) rst_out[i] <= 1'b0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        rst_out <= '1;
                        ready   <= 1'b0;
                        if (relock_count != '1) relock_count <= relock_count + 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                default: begin
                    state <= PLL_RST;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed + randomised bench for clk_reset_seq against an event-count model.
module tb_clk_reset_seq;

    localparam int NSYNC = 2, PRST = 3, TMO = 20, STB = 4, NCH = 3, STG = 2, CNT_W = 2;
    localparam int REL0     = STB + 1;                  // lock-held count at channel 0 release
    localparam int READY_AT = REL0 + STG * (NCH - 1) + 1;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lock_raw = 1'b0;
    logic             pll_resetb;
    logic [NCH-1:0]   rst_out;
    logic             ready;
    logic [CNT_W-1:0] relock_count;
    logic             timeout_err;

    int checks = 0;
    int failures = 0;

    // Model: remaining PLL-reset edges, unlocked wait length, cycles lock has
    // been held since acquisition (0 = not acquired).
    logic           m_sh [NSYNC];
    int             m_prst, m_wait, m_up, m_relock;
    logic           m_terr, m_pllb, m_ready;
    logic [NCH-1:0] m_rst;

    always #5 clk = ~clk;

    clk_reset_seq #(
        .NSYNC(NSYNC), .PLL_RST_CYCLES(PRST), .TIMEOUT_CYCLES(TMO), .STABLE_CYCLES(STB),
        .NCH(NCH), .STAGGER(STG), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock_raw     (lock_raw),
        .pll_resetb   (pll_resetb),
        .rst_out      (rst_out),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l);
        logic ls;
        ls = m_sh[NSYNC-1];
        if (r) begin
            for (int i = 0; i < NSYNC; i++) m_sh[i] = 1'b0;
            m_prst = PRST; m_wait = 0; m_up = 0; m_relock = 0; m_terr = 1'b0;
        end else begin
            for (int i = NSYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = l;
            if (m_prst > 0) begin
                m_prst--;
            end else if (m_up == 0) begin
                if (ls) m_up = 1;
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_terr = 1'b1; m_prst = PRST; m_wait = 0;
                    end
                end
            end else if (!ls) begin
                if (m_up >= READY_AT && m_relock < CMAX) m_relock++;
                m_up = 0; m_wait = 0;
            end else if (m_up < READY_AT) begin
                m_up++;
            end
        end
        m_pllb  = (m_prst == 0);
        m_ready = (m_up >= READY_AT);
        for (int i = 0; i < NCH; i++) m_rst[i] = !(m_up >= REL0 + STG * i);
    endtask

    task automatic cyc(input logic r, input logic l);
        rst = r; lock_raw = l;
        @(posedge clk);
        model_step(r, l);
        #1;
        chk("m_pll_resetb",   32'(pll_resetb),   32'(m_pllb));
        chk("m_rst_out",      32'(rst_out),      32'(m_rst));
        chk("m_ready",        32'(ready),        32'(m_ready));
        chk("m_relock_count", 32'(relock_count), 32'(m_relock));
        chk("m_timeout_err",  32'(timeout_err),  32'(m_terr));
    endtask

    task automatic run(input int n, input logic r, input logic l);
        for (int i = 0; i < n; i++) cyc(r, l);
    endtask

    initial begin
        // Cold start
        run(5, 1'b1, 1'b0);
        chk("rst_pllb", 32'(pll_resetb), 0);
        chk("rst_rst_out", 32'(rst_out), 7);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_relock", 32'(relock_count), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        run(2, 1'b0, 1'b0);
        chk("cold_pll_low", 32'(pll_resetb), 0);
        cyc(1'b0, 1'b0);
        chk("cold_pll_high", 32'(pll_resetb), 1);
        run(2, 1'b0, 1'b0);
        run(6, 1'b0, 1'b1);
        chk("cold_pre_rel", 32'(rst_out), 7);
        cyc(1'b0, 1'b1);
        chk("cold_rel0", 32'(rst_out), 6);
        run(2, 1'b0, 1'b1);
        chk("cold_rel1", 32'(rst_out), 4);
        run(2, 1'b0, 1'b1);
        chk("cold_rel2", 32'(rst_out), 0);
        chk("cold_not_ready", 32'(ready), 0);
        cyc(1'b0, 1'b1);
        chk("cold_ready", 32'(ready), 1);

        // Glitch during STABLE restarts the full stable count
        run(2, 1'b1, 1'b0);
        run(5, 1'b0, 1'b0);
        run(4, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        run(6, 1'b0, 1'b1);
        chk("glitch_held", 32'(rst_out), 7);
        cyc(1'b0, 1'b1);
        chk("glitch_rel0", 32'(rst_out), 6);
        chk("glitch_relock", 32'(relock_count), 0);
        run(5, 1'b0, 1'b1);
        chk("glitch_ready", 32'(ready), 1);

        // One RUN loss, then loss timed onto channel 1's release edge
        run(4, 1'b0, 1'b0);
        chk("mid_first_loss", 32'(relock_count), 1);
        run(6, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("mid_rel0", 32'(rst_out), 6);
        cyc(1'b0, 1'b0);
        chk("mid_hold", 32'(rst_out), 6);
        cyc(1'b0, 1'b0);
        chk("mid_loss", 32'(rst_out), 7);
        chk("mid_relock", 32'(relock_count), 1);

        // Repeated RUN losses; counter saturates
        run(2, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            run(14, 1'b0, 1'b1);
            chk("loss_ready", 32'(ready), 1);
            run(2, 1'b0, 1'b0);
            chk("loss_not_yet", 32'(rst_out), 0);
            cyc(1'b0, 1'b0);
            chk("loss_rst_out", 32'(rst_out), 7);
            chk("loss_ready0", 32'(ready), 0);
            chk("loss_relock", 32'(relock_count), (k < CMAX) ? k : CMAX);
        end

        // rst while in RUN
        run(14, 1'b0, 1'b1);
        chk("run_ready", 32'(ready), 1);
        cyc(1'b1, 1'b1);
        chk("rr_pll", 32'(pll_resetb), 0);
        chk("rr_rst_out", 32'(rst_out), 7);
        chk("rr_ready", 32'(ready), 0);
        chk("rr_relock", 32'(relock_count), 0);
        chk("rr_terr", 32'(timeout_err), 0);

        // Lock timeout and PLL retry period
        cyc(1'b1, 1'b0);
        run(22, 1'b0, 1'b0);
        chk("tmo_before", 32'(timeout_err), 0);
        chk("tmo_pll_before", 32'(pll_resetb), 1);
        cyc(1'b0, 1'b0);
        chk("tmo_err", 32'(timeout_err), 1);
        chk("tmo_pll_low", 32'(pll_resetb), 0);
        run(2, 1'b0, 1'b0);
        chk("tmo_pll_low2", 32'(pll_resetb), 0);
        cyc(1'b0, 1'b0);
        chk("tmo_pll_up", 32'(pll_resetb), 1);
        run(19, 1'b0, 1'b0);
        chk("tmo_pll_up2", 32'(pll_resetb), 1);
        cyc(1'b0, 1'b0);
        chk("tmo_repeat", 32'(pll_resetb), 0);
        chk("tmo_rst_out", 32'(rst_out), 7);
        chk("tmo_ready", 32'(ready), 0);

        // Random lock waveform with occasional rst pulses
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 15) == 0)
                run($urandom_range(1, 3), 1'b1, 1'b0);
            else if (seg % 2 == 0)
                run($urandom_range(1, 25), 1'b0, 1'b1);
            else
                run($urandom_range(1, 30), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
